// File: rtl/ssp_pkg.sv
// Shared constants and FSM state type for the SSP master.
// Frame layout: {RA[2:0], WnR, DI[11:0]}, MSB first on the wire.
package ssp_pkg;

    localparam int FRM_W   = 16;
    localparam int RA_MSB  = 15;
    localparam int RA_LSB  = 13;
    localparam int WNR_BIT = 12;
    localparam int DAT_W   = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/ssp_master_if.sv
// Host request/response and SSP pin bundle for ssp_master.
// master: the ssp_master view; slave: the host + pin-side view.
interface ssp_master_if;
    import ssp_pkg::*;

    logic                 Start;
    logic [2:0]           RA;
    logic                 WnR;
    logic [DAT_W-1:0]     DI;
    logic                 Busy;
    logic                 Done;
    logic [FRM_W-1:0]     RxD;
    logic                 nSSEL;
    logic                 SCK;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  Start, RA, WnR, DI, MISO,
        output Busy, Done, RxD, nSSEL, SCK, MOSI
    );

    modport slave (
        output Start, RA, WnR, DI, MISO,
        input  Busy, Done, RxD, nSSEL, SCK, MOSI
    );

endinterface

// File: rtl/ssp_sck_gen.sv
// SCK generator: half-period divider (DIV+1 Clk) and SCK toggle.
// Ports: Clk, Rst (async low), En (toggle on tick), Clr (hold divider, SCK=1) -> tick, SCK, rise, fall.
module ssp_sck_gen #(
    parameter int DIV = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Clr,
    output logic tick,
    output logic SCK,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_TC = 8'(DIV);

    logic [7:0] divCnt;

    // The divider keeps running while SCK is frozen (En low) so that
    // HOLD and GAP are still timed in half-periods.
    assign tick = ~Clr & (divCnt == DIV_TC);
    assign rise = tick & En & ~SCK;
    assign fall = tick & En & SCK;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            divCnt <= '0;
            SCK    <= 1'b1;
        end else if (Clr) begin
            divCnt <= '0;
            SCK    <= 1'b1;
        end else begin
            if (tick) divCnt <= '0;
            else      divCnt <= divCnt + 8'd1;
            if (tick && En) SCK <= ~SCK;
        end
    end

endmodule

// File: rtl/ssp_master.sv
// SSP master (SPI mode 3): sends {RA,WnR,DI}, collects 16 MISO bits into RxD.
// Ports: Clk, Rst (async low), bus (ssp_master_if.master); LpBk only with SSP_MASTER_LOOPBACK_EN.
module ssp_master #(
    parameter int DIV = 1,
    parameter int GAP = 2
) (
    input  logic Clk,
    input  logic Rst,
`ifdef SSP_MASTER_LOOPBACK_EN
    input  logic LpBk,
`endif
    ssp_master_if.master bus
);
    import ssp_pkg::*;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [4:0] BITS     = 5'(FRM_W);

    state_t             state;
    logic [FRM_W-1:0]   txSr;
    logic [FRM_W-1:0]   rxSr;
    logic [FRM_W-1:0]   rxD;
    logic [4:0]         bitCnt;
    logic [3:0]         gapCnt;
    logic               lead;
    logic               busy;
    logic               done;
    logic               nSsel;
    logic               mosi;
    logic               misoIn;
    logic               sckEn;
    logic               sckClr;
    logic               tick;
    logic               sck;
    logic               rise;
    logic               fall;

`ifdef SSP_MASTER_LOOPBACK_EN
    assign misoIn = LpBk ? mosi : bus.MISO;
`else
    assign misoIn = bus.MISO;
`endif

    // SETUP spends one half-period as nSSEL lead, then SCK falls on the
    // second tick. SHIFT stops toggling once 16 bits are in, leaving SCK
    // high for its last half-period before HOLD.
    assign sckClr = (state == IDLE);
    assign sckEn  = ((state == SHIFT) && (bitCnt != BITS))
                  || ((state == SETUP) && lead);

    ssp_sck_gen #(.DIV(DIV)) u_sck (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (sckEn),
        .Clr  (sckClr),
        .tick (tick),
        .SCK  (sck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            txSr   <= '0;
            rxSr   <= '0;
            rxD    <= '0;
            bitCnt <= '0;
            gapCnt <= '0;
            lead   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            nSsel  <= 1'b1;
            mosi   <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start && !busy) begin
                        txSr   <= {bus.RA, bus.WnR, bus.DI};
                        mosi   <= bus.RA[2];
                        nSsel  <= 1'b0;
                        busy   <= 1'b1;
                        bitCnt <= '0;
                        lead   <= 1'b0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        if (lead) state <= SHIFT;
                        else      lead  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        rxSr <= {rxSr[FRM_W-2:0], misoIn};
                        if (bitCnt != BITS) bitCnt <= bitCnt + 5'd1;
                    end
                    if (fall) begin
                        txSr <= txSr << 1;
                        mosi <= txSr[FRM_W-2];
                    end
                    if (tick && (bitCnt == BITS)) state <= HOLD;
                end
                HOLD: begin
                    if (tick) begin
                        nSsel  <= 1'b1;
                        mosi   <= 1'b1;
                        rxD    <= rxSr;
                        done   <= 1'b1;
                        gapCnt <= '0;
                        state  <= ssp_pkg::GAP;
                    end
                end
                ssp_pkg::GAP: begin
                    if (tick) begin
                        if (gapCnt == GAP_LAST) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gapCnt <= gapCnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.RxD   = rxD;
    assign bus.nSSEL = nSsel;
    assign bus.SCK   = sck;
    assign bus.MOSI  = mosi;

endmodule
